// File: rtl/debug_pkg.sv
// Shared definitions for the fetch-trace / breakpoint unit: FSM state codes
// and the bit placement of each breakpoint address inside the packed bp_addr bus.
package debug_pkg;

  typedef enum logic [1:0] {
    DBG_RUN     = 2'd0,
    DBG_STOPPED = 2'd1,
    DBG_STEP    = 2'd2,
    DBG_HALTED  = 2'd3
  } dbg_state_e;

  // Channel ch occupies bp_addr[ch*pc_w +: pc_w].
  function automatic int bp_lsb(input int ch, input int pc_w);
    return ch * pc_w;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular trace buffer with show-ahead read, overwrite-oldest on full,
// sticky overflow flag and a synchronous flush.
module trace_ring #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          full_s;
  logic          do_rd_s;

  assign full_s   = (count_r == CW'(DEPTH));
  assign do_rd_s  = rd_en & (count_r != {CW{1'b0}});
  assign rd_data  = mem[rd_ptr_r];
  assign count    = count_r;
  assign overflow = overflow_r;

  // Storage array; a flush drops any write in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer / occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (wr_en && do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else if (wr_en && full_s) begin
        // Full: the oldest entry is overwritten, so the head moves with it.
        rd_ptr_r   <= rd_ptr_r + AW'(1);
        overflow_r <= 1'b1;
      end else if (wr_en) begin
        count_r <= count_r + CW'(1);
      end else if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r  <= count_r - CW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_trace_unit.sv
// Fetch-trace and breakpoint unit: snoops CPU fetches into a trace ring and
// freezes the CPU on PC breakpoints, single-step, or HALT.
module debug_trace_unit
  import debug_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_valid,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       halt_in,
  input  logic [NUM_BP-1:0]          bp_en,
  input  logic [NUM_BP*PC_W-1:0]     bp_addr,
  input  logic                       step_req,
  input  logic                       resume_req,
  input  logic                       clear,
  input  logic                       rd_en,
  output logic [PC_W-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       cpu_stall,
  output logic [NUM_BP-1:0]          bp_hit,
  output logic [1:0]                 state_o
);

  dbg_state_e        state_r;
  dbg_state_e        state_nxt_s;
  logic [NUM_BP-1:0] bp_hit_r;
  logic [NUM_BP-1:0] bp_hit_nxt_s;
  logic [NUM_BP-1:0] match_s;
  logic              capture_s;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign match_s[i] = bp_en[i] & (fetch_pc == bp_addr[bp_lsb(i, PC_W) +: PC_W]);
  end

  // Next-state, breakpoint-hit capture and trace-write qualification.
  always_comb begin
    state_nxt_s  = state_r;
    bp_hit_nxt_s = bp_hit_r;
    capture_s    = 1'b0;
    case (state_r)
      DBG_RUN: begin
        capture_s = fetch_valid;
        if (fetch_valid && (|match_s)) begin
          state_nxt_s  = DBG_STOPPED;
          bp_hit_nxt_s = match_s;
        end else begin
          state_nxt_s = DBG_RUN;
        end
      end
      DBG_STOPPED: begin
        if (step_req) begin
          state_nxt_s  = DBG_STEP;
          bp_hit_nxt_s = {NUM_BP{1'b0}};
        end else if (resume_req) begin
          state_nxt_s  = DBG_RUN;
          bp_hit_nxt_s = {NUM_BP{1'b0}};
        end else begin
          state_nxt_s = DBG_STOPPED;
        end
      end
      DBG_STEP: begin
        capture_s = fetch_valid;
        if (fetch_valid) begin
          state_nxt_s  = DBG_STOPPED;
          bp_hit_nxt_s = match_s;
        end else begin
          state_nxt_s = DBG_STEP;
        end
      end
      DBG_HALTED: state_nxt_s = DBG_HALTED;
      default:    state_nxt_s = DBG_RUN;
    endcase
    if (halt_in) begin
      state_nxt_s = DBG_HALTED;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // FSM state and sticky hit vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= DBG_RUN;
      bp_hit_r <= {NUM_BP{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      bp_hit_r <= bp_hit_nxt_s;
    end
  end

  // Combinational so the CPU freezes in the very IF1 cycle that hits.
  assign cpu_stall = (state_r == DBG_STOPPED) | (state_r == DBG_HALTED)
                   | (fetch_valid & (state_r == DBG_RUN) & (|match_s))
                   | (fetch_valid & (state_r == DBG_STEP));
  assign bp_hit    = bp_hit_r;
  assign state_o   = state_r;

  trace_ring #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .wr_en    (capture_s),
    .wr_data  (fetch_pc),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: doc/debug_trace_unit.md
# debug_trace_unit

Parametrised fetch-trace and breakpoint unit for the lab CPU. It sits beside the CPU and snoops every instruction fetch (the cycle the CPU enters its IF1/address-select state). It records each fetched PC in a circular trace buffer and can freeze the CPU on any of `NUM_BP` PC breakpoints or single-step it. It makes the bench-only "print PC at every fetch" monitor synthesizable and host-readable.

## Interface
- `PC_W`, 9: PC width.
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `NUM_BP`, 2: breakpoint channels, 1..8.
- `clk` in 1: CPU clock; all state changes on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: one-cycle pulse when CPU enters IF1; never re-pulsed while `cpu_stall`=1.
- `fetch_pc` in `PC_W`: PC of that fetch, valid with `fetch_valid`.
- `halt_in` in 1: CPU executed HALT (break LED).
- `bp_en` in `NUM_BP`: per-channel enable.
- `bp_addr` in `NUM_BP*PC_W`: channel i at bits `[i*PC_W +: PC_W]`.
- `step_req` in 1: single-step pulse.
- `resume_req` in 1: run pulse.
- `clear` in 1: synchronous trace flush.
- `rd_en` in 1: pop oldest trace entry.
- `rd_data` out `PC_W`: oldest entry (show-ahead).
- `count` out `$clog2(DEPTH)+1`: entries held.
- `overflow` out 1: sticky; an entry was overwritten.
- `cpu_stall` out 1: freeze CPU in IF1.
- `bp_hit` out `NUM_BP`: channel(s) that caused the last stop; held until run resumes.
- `state_o` out 2: FSM state code.

## Operation
- FSM states: RUN=0, STOPPED=1, STEP=2, HALTED=3. Reset → RUN.
- Capture: every `fetch_valid` in RUN or STEP writes `fetch_pc` at `wr_ptr`. In STOPPED or HALTED, `fetch_valid` is ignored.
- Match: `match[i] = bp_en[i] & (fetch_pc == bp_addr[i])`, evaluated only on `fetch_valid`.
- RUN, `fetch_valid` with any match → STOPPED. `bp_hit` ← match vector. The PC is still recorded.
- STOPPED:
  - `step_req` → STEP, `bp_hit` cleared.
  - `resume_req` → RUN, `bp_hit` cleared.
  - Both asserted together: step wins.
- STEP: the next `fetch_valid` → STOPPED. `bp_hit` ← match vector, which may be zero.
- `halt_in`=1 in any state → HALTED. This has priority over all other transitions. HALTED is left only by reset.
- `cpu_stall` = (state==STOPPED) | (state==HALTED) | (`fetch_valid` & state==RUN & |match) | (`fetch_valid` & state==STEP).
  - This is combinational, so the CPU is frozen in the same IF1 cycle as the hit. No instruction at a breakpoint PC ever executes before the stop.
- Buffer:
  - Write when not full: `count`+1.
  - Write when full: overwrite oldest, advance `rd_ptr`, set `overflow`, `count` unchanged.
  - `rd_en` when `count`=0 is ignored; `rd_data` is then don't-care.
  - Write and read in the same cycle: both pointers advance and `count` is unchanged. This applies whether the buffer is full or not, and sets no overflow.
  - `clear`: pointers to 0, `count` to 0, `overflow` to 0. A write in the same cycle is dropped. Does not change FSM state.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` saturates at DEPTH by construction.

## Timing
- Reset values: state RUN, `cpu_stall` 0, `bp_hit` 0, `count` 0, `overflow` 0, pointers 0, `rd_data` = mem[0] (don't-care).
- Trace write latency 1: the entry is visible in `count`/`rd_data` the cycle after `fetch_valid`.
- `rd_data` updates the cycle after `rd_en`.
- Stop on a match: `cpu_stall` rises in the `fetch_valid` cycle; `state_o`=STOPPED next cycle.
- Resume: `cpu_stall` falls the cycle after `resume_req`/`step_req` is sampled.
- `reset_n` mid-stop releases `cpu_stall` asynchronously. Buffer contents are lost.

## Structure
- Shared package `debug_pkg`: state codes `DBG_RUN`, `DBG_STOPPED`, `DBG_STEP`, `DBG_HALTED`, and the `bp_addr` packing rule.
- One sub-module, `trace_ring`, holds the circular buffer (pointers, count, overflow, clear). The FSM and breakpoint comparators stay in the top.

## Test plan
- Reset, then 5 fetches PC 0..4, no breakpoints → `count`=5; pops return 0,1,2,3,4; `cpu_stall` never 1.
- DEPTH=16, 20 fetches PC 0..19 → `count`=16, `overflow`=1, first pop = 4.
- bp0=0x007 enabled, fetches 5,6,7 → `cpu_stall` high in the PC-7 cycle; `bp_hit`=01; `state_o`=1. Trace holds 5,6,7. A further `fetch_valid` is not recorded.
- From that stop: `step_req`, fetch 8 → stops again with `bp_hit`=00. Then `resume_req`, fetch 9,10 → RUN, no stall, trace ends ...8,9,10.
- Full buffer with simultaneous `rd_en` and `fetch_valid` → `count` stays 16, `overflow` unchanged. Then `clear` with `fetch_valid` → `count`=0.
- `halt_in` pulse during STEP → HALTED, `cpu_stall`=1. `resume_req` has no effect. `reset_n` low → `cpu_stall`=0 immediately, state RUN.
